// File: rtl/vector_dot_product_par.sv
// vector_dot_product_par
//   Multi-lane signed dot-product engine. Framed input beats carry LANES
//   element pairs. Each beat's lane products are summed and registered (S1).
//   The per-frame FSM accumulates the beat sums (S2). Each frame's result is
//   then delivered through a single-entry valid/ready output register that
//   back-pressures the input.
//
//   Optional feature: define DOT_SAT_EN for saturating accumulation plus the
//   sat flag. Without it, accumulation wraps at ACC_W and sat is tied 0.
//
// Ports
//   clk, rst           : clock, synchronous active-high reset
//   in_valid/in_ready  : input beat handshake
//   sop, eop           : first / last beat of a vector
//   data_a, data_b     : LANES packed signed elements, lane i at [i*DATA_W +: DATA_W]
//   result, result_len : signed frame dot product and its beat count
//   result_valid       : result/result_len valid
//   out_ready          : consumer accepts the result
//   err                : sticky protocol-error flag
//   sat                : saturation occurred in the delivered frame
module vector_dot_product_par #(
  parameter int DATA_W = 8,
  parameter int LANES  = 4,
  parameter int ACC_W  = 32,
  parameter int CNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      sop,
  input  logic                      eop,
  input  logic [LANES*DATA_W-1:0]   data_a,
  input  logic [LANES*DATA_W-1:0]   data_b,
  output logic [ACC_W-1:0]          result,
  output logic [CNT_W-1:0]          result_len,
  output logic                      result_valid,
  input  logic                      out_ready,
  output logic                      err,
  output logic                      sat
);

  typedef enum logic {IDLE, FRAME} state_t;

  logic adv;

  // S1: lane products summed, sign-extended to ACC_W
  logic signed [2*DATA_W-1:0] prod;
  logic [ACC_W-1:0]           sum_d;
  logic [ACC_W-1:0]           sum1_q;
  logic                       v1_q, sop1_q, eop1_q;

  // S2: frame accumulator and FSM
  state_t           state_q;
  logic [ACC_W-1:0] acc_q, base, step_acc;
  logic [CNT_W-1:0] len_q, step_len;
  logic             err_q;

  // Completed-frame stage feeding the output register
  logic             fin_v_q;
  logic [ACC_W-1:0] fin_acc_q;
  logic [CNT_W-1:0] fin_len_q;

  // Output register
  logic             rv_q;
  logic [ACC_W-1:0] result_q;
  logic [CNT_W-1:0] rlen_q;

  assign adv          = !(rv_q && !out_ready);
  assign in_ready     = adv;
  assign result       = result_q;
  assign result_len   = rlen_q;
  assign result_valid = rv_q;
  assign err          = err_q;

  always_comb begin
    sum_d = '0;
    prod  = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      prod  = $signed(data_a[i*DATA_W +: DATA_W]) * $signed(data_b[i*DATA_W +: DATA_W]);
      sum_d = sum_d + ACC_W'(prod);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q   <= 1'b0;
      sop1_q <= 1'b0;
      eop1_q <= 1'b0;
      sum1_q <= '0;
    end else if (adv) begin
      v1_q <= in_valid;
      if (in_valid) begin
        sop1_q <= sop;
        eop1_q <= eop;
        sum1_q <= sum_d;
      end
    end
  end

  // A sop beat (fresh or restarting) loads, anything else accumulates.
  assign base     = sop1_q ? '0 : acc_q;
  assign step_len = sop1_q ? CNT_W'(1) : len_q + CNT_W'(1);

`ifdef DOT_SAT_EN
  logic [ACC_W:0] wide_sum;
  logic           step_clamp, step_sat;
  logic           frame_sat_q, fin_sat_q, sat_q;

  always_comb begin
    wide_sum   = {base[ACC_W-1], base} + {sum1_q[ACC_W-1], sum1_q};
    step_clamp = wide_sum[ACC_W] ^ wide_sum[ACC_W-1];
    if (!step_clamp)
      step_acc = wide_sum[ACC_W-1:0];
    else if (wide_sum[ACC_W])
      step_acc = {1'b1, {(ACC_W-1){1'b0}}};
    else
      step_acc = {1'b0, {(ACC_W-1){1'b1}}};
    step_sat = step_clamp | (!sop1_q & frame_sat_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_sat_q <= 1'b0;
      fin_sat_q   <= 1'b0;
      sat_q       <= 1'b0;
    end else if (adv) begin
      if (v1_q && !(state_q == IDLE && !sop1_q)) begin
        frame_sat_q <= step_sat;
        if (eop1_q)
          fin_sat_q <= step_sat;
      end
      if (fin_v_q)
        sat_q <= fin_sat_q;
    end
  end

  assign sat = sat_q;
`else
  assign step_acc = base + sum1_q;
  assign sat      = 1'b0;
`endif

  // The completed frame passes through fin_* before the output register,
  // so result_valid rises two edges after the eop beat enters S1.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      len_q     <= '0;
      err_q     <= 1'b0;
      fin_v_q   <= 1'b0;
      fin_acc_q <= '0;
      fin_len_q <= '0;
    end else if (adv) begin
      fin_v_q <= 1'b0;
      if (v1_q) begin
        if (state_q == IDLE && !sop1_q) begin
          err_q <= 1'b1;
        end else begin
          if (state_q == FRAME && sop1_q)
            err_q <= 1'b1;
          acc_q <= step_acc;
          len_q <= step_len;
          if (eop1_q) begin
            fin_v_q   <= 1'b1;
            fin_acc_q <= step_acc;
            fin_len_q <= step_len;
            state_q   <= IDLE;
          end else begin
            state_q <= FRAME;
          end
        end
      end
    end
  end

  // While adv is high the register is either empty or being consumed, so
  // it simply takes whatever the completed-frame stage offers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rv_q     <= 1'b0;
      result_q <= '0;
      rlen_q   <= '0;
    end else if (adv) begin
      rv_q <= fin_v_q;
      if (fin_v_q) begin
        result_q <= fin_acc_q;
        rlen_q   <= fin_len_q;
      end
    end
  end

endmodule

// File: tb/tb_vector_dot_product_par.sv
module tb_vector_dot_product_par;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, sop = 1'b0, eop = 1'b0, out_ready = 1'b1;
  logic [31:0] data_a = '0, data_b = '0;
  logic        in_ready, result_valid, err, sat;
  logic [31:0] result;
  logic [15:0] result_len;

  // Narrow single-lane instance for the wrap/saturation case
  logic        s_in_valid = 1'b0, s_sop = 1'b0, s_eop = 1'b0, s_out_ready = 1'b1;
  logic [7:0]  s_a = '0, s_b = '0;
  logic        s_in_ready, s_rv, s_err, s_sat;
  logic [17:0] s_result;
  logic [15:0] s_len;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  bit          m_open = 0;
  longint      m_acc = 0;
  int          m_len = 0;
  bit          m_err = 0;
  logic [31:0] exp_res[$];
  logic [15:0] exp_len[$];

  always #5 clk = ~clk;

  vector_dot_product_par #(.DATA_W(8), .LANES(4), .ACC_W(32), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .sop(sop), .eop(eop), .data_a(data_a), .data_b(data_b),
    .result(result), .result_len(result_len), .result_valid(result_valid),
    .out_ready(out_ready), .err(err), .sat(sat)
  );

  vector_dot_product_par #(.DATA_W(8), .LANES(1), .ACC_W(18), .CNT_W(16)) u_small (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .sop(s_sop), .eop(s_eop), .data_a(s_a), .data_b(s_b),
    .result(s_result), .result_len(s_len), .result_valid(s_rv),
    .out_ready(s_out_ready), .err(s_err), .sat(s_sat)
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pk(input int x0, input int x1, input int x2, input int x3);
    return {x3[7:0], x2[7:0], x1[7:0], x0[7:0]};
  endfunction

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until accepted; returns 1 time unit after
  // the accepting edge with in_valid dropped.
  task automatic send(input logic s, input logic e, input logic [31:0] a, input logic [31:0] b);
    int unsigned n;
    n = 0;
    in_valid = 1'b1; sop = s; eop = e; data_a = a; data_b = b;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout in_ready stuck low at %0t", $time);
    end
    sync();
    in_valid = 1'b0;
  endtask

  task automatic wait_rv(input string nm);
    int unsigned n;
    n = 0;
    @(negedge clk);
    while (!result_valid && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!result_valid) begin
      checks++; errors++;
      $display("FAIL %s result_valid never rose at %0t", nm, $time);
    end
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_in_ready"}, in_ready, 1);
    chk({nm, "_result_valid"}, result_valid, 0);
    chk({nm, "_result"}, result, 0);
    chk({nm, "_result_len"}, result_len, 0);
    chk({nm, "_err"}, err, 0);
    chk({nm, "_sat"}, sat, 0);
  endtask

  // Monitor: checks outputs against the frame model every cycle and updates
  // the model from the beats that will be accepted on the next edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        m_open = 0; m_acc = 0; m_len = 0; m_err = 0;
        exp_res.delete();
        exp_len.delete();
      end else begin
        checks++;
        if (in_ready !== !(result_valid && !out_ready)) begin
          errors++;
          $display("FAIL mon_in_ready actual=%b required=%b at %0t",
                   in_ready, !(result_valid && !out_ready), $time);
        end
        if (result_valid) begin
          checks++;
          if (exp_res.size() == 0) begin
            errors++;
            $display("FAIL mon_spurious result_valid with result=%0d, none expected at %0t",
                     $signed(result), $time);
          end else begin
            if (result !== exp_res[0] || result_len !== exp_len[0] || sat !== 1'b0) begin
              errors++;
              $display("FAIL mon_result actual=%0d/%0d/sat%b required=%0d/%0d/sat0 at %0t",
                       $signed(result), result_len, sat, $signed(exp_res[0]), exp_len[0], $time);
            end
            if (out_ready) begin
              void'(exp_res.pop_front());
              void'(exp_len.pop_front());
            end
          end
        end
        if (in_valid && in_ready) begin
          longint s;
          s = 0;
          for (int i = 0; i < 4; i++)
            s += longint'($signed(data_a[i*8 +: 8])) * longint'($signed(data_b[i*8 +: 8]));
          if (!m_open && !sop) begin
            m_err = 1;
          end else begin
            if (sop) begin
              if (m_open) m_err = 1;
              m_acc = s; m_len = 1;
            end else begin
              m_acc += s; m_len++;
            end
            m_open = 1;
            if (eop) begin
              exp_res.push_back(32'(m_acc));
              exp_len.push_back(16'(m_len));
              m_open = 0;
            end
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int took, cyc, frames, fbeat, flen;

    // Reset
    repeat (3) sync();
    rst = 1'b0;
    @(negedge clk);
    chk_reset_vals("rst0");
    sync();

    // Single-lane style frame [2,-3,4].[5,2,1] = 8, with latency pin
    send(1'b1, 1'b0, pk(2, 0, 0, 0), pk(5, 0, 0, 0));
    send(1'b0, 1'b0, pk(-3, 0, 0, 0), pk(2, 0, 0, 0));
    send(1'b0, 1'b1, pk(4, 0, 0, 0), pk(1, 0, 0, 0));
    @(negedge clk); chk("lat_edge_k", result_valid, 0);
    @(negedge clk); chk("lat_edge_k1", result_valid, 0);
    @(negedge clk); chk("lat_edge_k2", result_valid, 1);
    chk("t1_result", $signed(result), 8);
    chk("t1_len", result_len, 3);
    sync();

    // Four lanes: 10 + 4*16384 = 65546
    send(1'b1, 1'b0, pk(1, 2, 3, 4), pk(1, 1, 1, 1));
    send(1'b0, 1'b1, pk(-128, -128, -128, -128), pk(-128, -128, -128, -128));
    wait_rv("t2");
    chk("t2_result", $signed(result), 65546);
    chk("t2_len", result_len, 2);
    sync();

    // Back-pressure: one-beat frame (-21) then a second frame (11)
    out_ready = 1'b0;
    send(1'b1, 1'b1, pk(7, 0, 0, 0), pk(-3, 0, 0, 0));
    send(1'b1, 1'b1, pk(1, 2, 0, 0), pk(3, 4, 0, 0));
    @(negedge clk);
    chk("stall_pre_valid", result_valid, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", result_valid, 1);
      chk("stall_result", $signed(result), -21);
      chk("stall_in_ready", in_ready, 0);
    end
    sync();
    out_ready = 1'b1;
    @(negedge clk);
    chk("stall_release_result", $signed(result), -21);
    @(negedge clk);
    chk("second_valid", result_valid, 1);
    chk("second_result", $signed(result), 11);
    chk("second_len", result_len, 1);
    sync();

    // Protocol errors
    send(1'b0, 1'b0, pk(1, 1, 1, 1), pk(1, 1, 1, 1));
    repeat (3) @(negedge clk);
    chk("drop_err", err, 1);
    chk("drop_no_result", result_valid, 0);
    sync();
    send(1'b1, 1'b0, pk(5, 0, 0, 0), pk(5, 0, 0, 0));
    send(1'b1, 1'b0, pk(2, 0, 0, 0), pk(3, 0, 0, 0));
    send(1'b0, 1'b1, pk(1, 0, 0, 0), pk(4, 0, 0, 0));
    wait_rv("restart");
    chk("restart_result", $signed(result), 10);
    chk("restart_len", result_len, 2);
    chk("restart_err", err, 1);
    sync();

    // Reset with a frame open and a beat in flight
    send(1'b1, 1'b0, pk(9, 9, 9, 9), pk(9, 9, 9, 9));
    rst = 1'b1;
    repeat (2) sync();
    rst = 1'b0;
    @(negedge clk);
    chk_reset_vals("rst1");
    repeat (4) @(negedge clk);
    chk("rst1_no_result", result_valid, 0);
    sync();

    // Narrow instance: 10 x 127*127 in an 18-bit accumulator
    for (int i = 0; i < 10; i++) begin
      s_in_valid = 1'b1; s_sop = (i == 0); s_eop = (i == 9);
      s_a = 8'd127; s_b = 8'd127;
      chk("small_in_ready", s_in_ready, 1);
      sync();
    end
    s_in_valid = 1'b0;
    begin
      int unsigned n;
      n = 0;
      @(negedge clk);
      while (!s_rv && n < 20) begin n++; @(negedge clk); end
    end
    chk("small_valid", s_rv, 1);
`ifdef DOT_SAT_EN
    chk("small_result", longint'(s_result), 131071);
    chk("small_sat", s_sat, 1);
`else
    chk("small_result", longint'(s_result), 161290 % 262144);
    chk("small_sat", s_sat, 0);
`endif
    chk("small_len", s_len, 10);
    chk("small_err", s_err, 0);
    sync();

    // Randomized frames with random back-pressure
    took = 0; cyc = 0; frames = 0; fbeat = 0; flen = 1;
    while ((frames < 40 || in_valid) && cyc < 5000) begin
      if (took != 0) in_valid = 1'b0;
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid && frames < 40 && $urandom_range(0, 4) != 0) begin
        if (fbeat == 0) flen = $urandom_range(1, 6);
        sop = (fbeat == 0);
        eop = (fbeat == flen - 1);
        data_a = $urandom;
        data_b = $urandom;
        in_valid = 1'b1;
        fbeat++;
        if (fbeat == flen) begin fbeat = 0; frames++; end
      end
      @(negedge clk);
      took = (in_valid && in_ready) ? 1 : 0;
      sync();
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (10) sync();
    @(negedge clk);
    chk("rand_frames_sent", frames, 40);
    chk("rand_drained", exp_res.size(), 0);
    chk("rand_err", err, longint'(m_err));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
